// File: rtl/watergirl_motion.sv
// Per-frame motion controller for the Watergirl sprite: walking, jump/gravity and clamping,
// all applied once per frame on the vsync falling edge.
module watergirl_motion #(
    parameter int START_X  = 320,
    parameter int X_MIN    = 25,
    parameter int X_MAX    = 614,
    parameter int Y_MIN    = 25,
    parameter int FLOOR_Y  = 454,
    parameter int X_STEP   = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic       airborne
);

    typedef enum logic [1:0] {
        GROUNDED = 2'b00,
        RISING   = 2'b01,
        FALLING  = 2'b10
    } state_t;

    localparam logic [10:0]        X_MIN_W  = 11'(X_MIN);
    localparam logic [10:0]        X_MAX_W  = 11'(X_MAX);
    localparam logic [10:0]        X_STEP_W = 11'(X_STEP);
    localparam logic signed [11:0] Y_MIN_W  = 12'(Y_MIN);
    localparam logic signed [11:0] FLOOR_W  = 12'(FLOOR_Y);
    localparam logic signed [5:0]  VY_JUMP  = -(6'(JUMP_V));
    localparam logic signed [5:0]  VY_GRAV  = 6'(GRAVITY);
    localparam logic signed [5:0]  VY_MAXF  = 6'(MAX_FALL);

    logic               vsync_q;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    state_t             state_q, state_d;
    logic               jump_armed_q, jump_armed_d;
    logic               airborne_q, airborne_d;

    logic               tick;
    logic [10:0]        x_ext, x_sub, x_add;
    logic signed [11:0] y_sum;
    logic signed [5:0]  vy_inc;

    assign tick = vsync_q & ~vsync;

    always_comb begin
        // NOTE: every _d starts at its hold value, so no path leaves it unassigned and no latch is inferred.
        x_d          = x_q;
        y_d          = y_q;
        vy_d         = vy_q;
        state_d      = state_q;
        jump_armed_d = jump_armed_q;

        // Clamp test is done before subtracting, so the 11-bit difference never wraps.
        x_ext  = {1'b0, x_q};
        x_sub  = x_ext - X_STEP_W;
        x_add  = x_ext + X_STEP_W;
        y_sum  = $signed({2'b00, y_q}) + 12'(vy_q);
        vy_inc = vy_q + VY_GRAV;

        if (tick) begin
            if (key_left && !key_right) begin
                x_d = (x_ext < X_MIN_W + X_STEP_W) ? X_MIN_W[9:0] : x_sub[9:0];
            end else if (key_right && !key_left) begin
                x_d = (x_add > X_MAX_W) ? X_MAX_W[9:0] : x_add[9:0];
            end

            if (!key_jump) begin
                jump_armed_d = 1'b1;
            end

            case (state_q)
                GROUNDED: begin
                    if (key_jump && jump_armed_q) begin
                        vy_d         = VY_JUMP;
                        jump_armed_d = 1'b0;
                        state_d      = RISING;
                    end
                end
                RISING: begin
                    if (y_sum < Y_MIN_W) begin
                        y_d     = Y_MIN_W[9:0];
                        vy_d    = '0;
                        state_d = FALLING;
                    end else begin
                        y_d  = y_sum[9:0];
                        vy_d = vy_inc;
                        if (!vy_inc[5]) begin
                            state_d = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (y_sum >= FLOOR_W) begin
                        y_d     = FLOOR_W[9:0];
                        vy_d    = '0;
                        state_d = GROUNDED;
                    end else begin
                        y_d  = y_sum[9:0];
                        vy_d = (vy_inc > VY_MAXF) ? VY_MAXF : vy_inc;
                    end
                end
                default: begin
                    y_d     = FLOOR_W[9:0];
                    vy_d    = '0;
                    state_d = GROUNDED;
                end
            endcase
        end

        airborne_d = (state_d == RISING) || (state_d == FALLING);
    end

    // vsync_q resets high so a low vsync right after reset is not mistaken for a falling edge.
    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            vsync_q      <= 1'b1;
            x_q          <= 10'(START_X);
            y_q          <= 10'(FLOOR_Y);
            vy_q         <= '0;
            state_q      <= GROUNDED;
            jump_armed_q <= 1'b1;
            airborne_q   <= 1'b0;
        end else begin
            vsync_q      <= vsync;
            x_q          <= x_d;
            y_q          <= y_d;
            vy_q         <= vy_d;
            state_q      <= state_d;
            jump_armed_q <= jump_armed_d;
            airborne_q   <= airborne_d;
        end
    end

    assign BallX    = x_q;
    assign BallY    = y_q;
    assign airborne = airborne_q;

endmodule

// File: tb/tb_watergirl_motion.sv
// Randomised and directed bench for watergirl_motion against an integer frame-level model.
module tb_watergirl_motion;

    localparam int START_X  = 320;
    localparam int X_MIN    = 25;
    localparam int X_MAX    = 614;
    localparam int Y_MIN    = 25;
    localparam int FLOOR_Y  = 454;
    localparam int X_STEP   = 2;
    localparam int JUMP_V   = 12;
    localparam int GRAVITY  = 1;
    localparam int MAX_FALL = 12;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       key_left, key_right, key_jump;
    logic [9:0] BallX, BallY;
    logic       airborne;

    int n_cmp = 0;
    int n_err = 0;

    // Frame-level reference: position, velocity and phase as plain integers.
    int mx, my, mvy;
    bit m_air, m_rise, m_armed;

    watergirl_motion dut (
        .vga_clk  (vga_clk),
        .reset    (reset),
        .vsync    (vsync),
        .key_left (key_left),
        .key_right(key_right),
        .key_jump (key_jump),
        .BallX    (BallX),
        .BallY    (BallY),
        .airborne (airborne)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = START_X; my = FLOOR_Y; mvy = 0;
        m_air = 0; m_rise = 0; m_armed = 1;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        if (l && !r) mx = (mx - X_STEP < X_MIN) ? X_MIN : mx - X_STEP;
        if (r && !l) mx = (mx + X_STEP > X_MAX) ? X_MAX : mx + X_STEP;
        if (!m_air) begin
            if (j && m_armed) begin
                m_air = 1; m_rise = 1; mvy = -JUMP_V; m_armed = 0;
            end
        end else if (m_rise) begin
            if (my + mvy < Y_MIN) begin
                my = Y_MIN; mvy = 0; m_rise = 0;
            end else begin
                my = my + mvy;
                mvy = mvy + GRAVITY;
                if (mvy >= 0) m_rise = 0;
            end
        end else begin
            if (my + mvy >= FLOOR_Y) begin
                my = FLOOR_Y; mvy = 0; m_air = 0;
            end else begin
                my = my + mvy;
                mvy = (mvy + GRAVITY > MAX_FALL) ? MAX_FALL : mvy + GRAVITY;
            end
        end
        if (!j) m_armed = 1;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_x"}, int'(BallX), mx);
        check({tag, "_y"}, int'(BallY), my);
        check({tag, "_air"}, int'(airborne), int'(m_air));
    endtask

    task automatic scramble_keys();
        key_left  = 1'($urandom_range(0, 1));
        key_right = 1'($urandom_range(0, 1));
        key_jump  = 1'($urandom_range(0, 1));
    endtask

    // One frame: tick cycle with the given keys, then non-tick cycles with random keys.
    task automatic frame(input bit l, input bit r, input bit j);
        @(negedge vga_clk);
        key_left = l; key_right = r; key_jump = j; vsync = 1'b0;
        model_tick(l, r, j);
        @(negedge vga_clk);
        compare_all("tick");
        repeat (2) begin
            scramble_keys();
            @(negedge vga_clk);
            compare_all("hold_lo");
        end
        vsync = 1'b1;
        repeat (2) begin
            scramble_keys();
            @(negedge vga_clk);
            compare_all("hold_hi");
        end
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1;
        key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
        model_reset();

        // Reset with vsync toggling, then release with vsync high.
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            vsync = ~vsync;
            key_right = 1'b1;
        end
        @(negedge vga_clk);
        reset = 1'b0; vsync = 1'b1;
        check("reset_x", int'(BallX), 320);
        check("reset_y", int'(BallY), 454);
        check("reset_air", int'(airborne), 0);
        repeat (4) begin
            @(negedge vga_clk);
            compare_all("pre_tick");
        end

        // Walk right, then both keys held.
        repeat (10) frame(1'b0, 1'b1, 1'b0);
        check("walk_right_x", int'(BallX), 340);
        check("walk_right_y", int'(BallY), 454);
        repeat (3) frame(1'b1, 1'b1, 1'b0);
        check("both_keys_x", int'(BallX), 340);

        // Left clamp.
        repeat (157) frame(1'b1, 1'b0, 1'b0);
        check("left_26", int'(BallX), 26);
        frame(1'b1, 1'b0, 1'b0);
        check("left_clamp", int'(BallX), 25);
        frame(1'b1, 1'b0, 1'b0);
        check("left_stay", int'(BallX), 25);

        // Full jump from the ground.
        frame(1'b0, 1'b0, 1'b1);
        check("jump_t1_air", int'(airborne), 1);
        check("jump_t1_y", int'(BallY), 454);
        frame(1'b0, 1'b0, 1'b0);
        check("jump_t2_y", int'(BallY), 442);
        repeat (11) frame(1'b0, 1'b1, 1'b0);
        check("jump_apex_y", int'(BallY), 376);
        repeat (13) frame(1'b0, 1'b0, 1'b0);
        check("jump_land_y", int'(BallY), 454);
        check("jump_land_air", int'(airborne), 0);

        // Jump held through landing must not re-jump.
        repeat (30) frame(1'b0, 1'b0, 1'b1);
        check("held_no_rejump_air", int'(airborne), 0);
        check("held_no_rejump_y", int'(BallY), 454);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        check("rejump_t1_air", int'(airborne), 1);
        check("rejump_t1_y", int'(BallY), 454);
        frame(1'b0, 1'b0, 1'b1);
        check("rejump_t2_y", int'(BallY), 442);
        repeat (30) frame(1'b0, 1'b0, 1'b0);

        // Randomised frames.
        for (int i = 0; i < 400; i++) begin
            bit l, r, j;
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            frame(l, r, j);
        end

        // Reset coinciding with a tick while rising.
        repeat (40) frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b1, 1'b1);
        repeat (4) frame(1'b0, 1'b1, 1'b0);
        check("pre_reset_air", int'(airborne), 1);
        @(negedge vga_clk);
        reset = 1'b1; vsync = 1'b0;
        key_left = 1'b1; key_right = 1'b0; key_jump = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0; vsync = 1'b1;
        model_reset();
        check("midair_reset_x", int'(BallX), 320);
        check("midair_reset_y", int'(BallY), 454);
        check("midair_reset_air", int'(airborne), 0);
        repeat (3) begin
            scramble_keys();
            @(negedge vga_clk);
            compare_all("post_reset");
        end
        frame(1'b0, 1'b0, 1'b1);
        check("post_reset_jump_air", int'(airborne), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
